// File: rtl/lock_pkg.sv
// lock_pkg
// Definitions shared by the password-lock datapath: key codes for the
// command keys, the debounce state encoding, the default code length used
// by both the key-entry front end and the lock FSM, and a small key
// classifier.
package lock_pkg;

  localparam int CODE_DIGITS_DEF = 4;

  localparam logic [3:0] KEY_DIGIT_MAX = 4'h9;
  localparam logic [3:0] KEY_ENTER     = 4'hD;
  localparam logic [3:0] KEY_CHANGE    = 4'hE;
  localparam logic [3:0] KEY_CLEAR     = 4'hF;

  typedef enum logic [1:0] {
    DB_REL       = 2'd0,
    DB_PRESS_CHK = 2'd1,
    DB_PRS       = 2'd2,
    DB_REL_CHK   = 2'd3
  } db_state_t;

  typedef enum logic [2:0] {
    KC_DIGIT  = 3'd0,
    KC_BAD    = 3'd1,
    KC_ENTER  = 3'd2,
    KC_CHANGE = 3'd3,
    KC_CLEAR  = 3'd4
  } key_class_t;

  // Maps a 4-bit key value onto the action class the entry logic acts on.
  function automatic key_class_t classify_key(input logic [3:0] k);
    key_class_t c;
    if (k <= KEY_DIGIT_MAX)   c = KC_DIGIT;
    else if (k == KEY_ENTER)  c = KC_ENTER;
    else if (k == KEY_CHANGE) c = KC_CHANGE;
    else if (k == KEY_CLEAR)  c = KC_CLEAR;
    else                      c = KC_BAD;
    return c;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// key_debounce
// Two-flop synchronizer plus debounce FSM for one active-low key.
//   clk    in   system clock
//   rst    in   asynchronous active-high reset
//   key_in in   raw key level, 0 = pressed, may bounce
//   press  out  combinational strobe, high in the cycle whose closing edge
//               moves the FSM into the stable-pressed state; the parent
//               registers it together with its decode results
module key_debounce
  import lock_pkg::*;
#(
  parameter int DB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic key_in,
  output logic press
);

  localparam int CNT_W = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic            key_p0;
  logic            key_p1;
  logic [1:0]      settle;
  logic            armed;
  db_state_t       state;
  db_state_t       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  // ---- stage p0/p1: synchronizer, released level out of reset ----
  // The synchronizer comes out of reset reading "released" whether or not
  // the key really is. 'armed' only rises once a released level has made it
  // through both flops after reset, so a key held across reset must be let
  // go and pressed again before it can produce an event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_p0 <= 1'b1;
      key_p1 <= 1'b1;
      settle <= 2'b00;
      armed  <= 1'b0;
    end else begin
      key_p0 <= key_in;
      key_p1 <= key_p0;
      settle <= {settle[0], 1'b1};
      if (settle[1] && key_p1)
        armed <= 1'b1;
    end
  end

  // ---- debounce FSM state register ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= DB_REL;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    press     = 1'b0;
    case (state)
      DB_REL: begin
        if (armed && !key_p1) begin
          state_nxt = DB_PRESS_CHK;
          cnt_nxt   = '0;
        end
      end
      DB_PRESS_CHK: begin
        if (key_p1) begin
          state_nxt = DB_REL;
        end else if (cnt == CNT_LAST) begin
          state_nxt = DB_PRS;
          press     = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      DB_PRS: begin
        if (key_p1) begin
          state_nxt = DB_REL_CHK;
          cnt_nxt   = '0;
        end
      end
      DB_REL_CHK: begin
        if (!key_p1) begin
          state_nxt = DB_PRS;
        end else if (cnt == CNT_LAST) begin
          state_nxt = DB_REL;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = DB_REL;
    endcase
  end

endmodule

// File: rtl/key_entry_ctrl.sv
// key_entry_ctrl
// Key-entry front end of the password lock. Debounces the entry key, samples
// the switch value on each accepted press and turns it into digit entry or
// a command pulse for the lock FSM.
//   clk        in   system clock
//   rst        in   asynchronous active-high reset
//   key_in     in   raw entry key, active low
//   sw         in   4-bit key value, sampled on a press
//   key_evt    out  one-cycle pulse per accepted press
//   code       out  last completed code, first digit in the MS nibble
//   code_valid out  one-cycle pulse, code updated in the same cycle
//   cmd_change out  one-cycle pulse on key E
//   cmd_clear  out  one-cycle pulse on key F
//   entry_err  out  one-cycle pulse on bad key, overflow or short entry
//   digit_cnt  out  digits currently buffered
//   disp_buf   out  live entry buffer, unused nibbles read 0
module key_entry_ctrl
  import lock_pkg::*;
#(
  parameter int DB_CYCLES   = 4,
  parameter int CODE_DIGITS = CODE_DIGITS_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     key_in,
  input  logic [3:0]               sw,
  output logic                     key_evt,
  output logic [4*CODE_DIGITS-1:0] code,
  output logic                     code_valid,
  output logic                     cmd_change,
  output logic                     cmd_clear,
  output logic                     entry_err,
  output logic [3:0]               digit_cnt,
  output logic [4*CODE_DIGITS-1:0] disp_buf
);

  localparam int BUF_W = 4 * CODE_DIGITS;
  localparam logic [3:0] CNT_FULL = 4'(CODE_DIGITS);

  logic [3:0]       sw_p0;
  logic [3:0]       sw_p1;
  logic             press;
  logic [BUF_W-1:0] shifted;
  logic [BUF_W-1:0] buf_nxt;
  logic [BUF_W-1:0] code_nxt;
  logic [3:0]       cnt_nxt;
  logic             valid_nxt;
  logic             chg_nxt;
  logic             clr_nxt;
  logic             err_nxt;

  key_debounce #(
    .DB_CYCLES (DB_CYCLES)
  ) u_debounce (
    .clk    (clk),
    .rst    (rst),
    .key_in (key_in),
    .press  (press)
  );

  // ---- stage p0/p1: switch synchronizer ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_p0 <= 4'h0;
      sw_p1 <= 4'h0;
    end else begin
      sw_p0 <= sw;
      sw_p1 <= sw_p0;
    end
  end

  // Decode acts on the press strobe directly so that key_evt, the command
  // pulse and the buffer update all land on the same clock edge.
  always_comb begin
    buf_nxt     = disp_buf;
    code_nxt    = code;
    cnt_nxt     = digit_cnt;
    valid_nxt   = 1'b0;
    chg_nxt     = 1'b0;
    clr_nxt     = 1'b0;
    err_nxt     = 1'b0;
    shifted     = disp_buf << 4;
    shifted[3:0] = sw_p1;
    if (press) begin
      case (classify_key(sw_p1))
        KC_DIGIT: begin
          if (digit_cnt < CNT_FULL) begin
            buf_nxt = shifted;
            cnt_nxt = digit_cnt + 4'd1;
          end else begin
            err_nxt = 1'b1;
          end
        end
        KC_ENTER: begin
          if (digit_cnt == CNT_FULL) begin
            code_nxt  = disp_buf;
            valid_nxt = 1'b1;
          end else begin
            err_nxt = 1'b1;
          end
          buf_nxt = '0;
          cnt_nxt = 4'd0;
        end
        KC_CHANGE: begin
          chg_nxt = 1'b1;
          buf_nxt = '0;
          cnt_nxt = 4'd0;
        end
        KC_CLEAR: begin
          clr_nxt = 1'b1;
          buf_nxt = '0;
          cnt_nxt = 4'd0;
        end
        default: err_nxt = 1'b1;
      endcase
    end
  end

  // ---- stage p2: registered decode results ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_evt    <= 1'b0;
      code       <= '0;
      code_valid <= 1'b0;
      cmd_change <= 1'b0;
      cmd_clear  <= 1'b0;
      entry_err  <= 1'b0;
      digit_cnt  <= 4'd0;
      disp_buf   <= '0;
    end else begin
      key_evt    <= press;
      code       <= code_nxt;
      code_valid <= valid_nxt;
      cmd_change <= chg_nxt;
      cmd_clear  <= clr_nxt;
      entry_err  <= err_nxt;
      digit_cnt  <= cnt_nxt;
      disp_buf   <= buf_nxt;
    end
  end

endmodule

// File: tb/tb_key_entry_ctrl.sv
// Directed bench for key_entry_ctrl with DB_CYCLES=4, CODE_DIGITS=4,
// 20 ns clock, each key held 10 cycles.
module tb_key_entry_ctrl;

  logic        clk;
  logic        rst;
  logic        key_in;
  logic [3:0]  sw;
  logic        key_evt;
  logic [15:0] code;
  logic        code_valid;
  logic        cmd_change;
  logic        cmd_clear;
  logic        entry_err;
  logic [3:0]  digit_cnt;
  logic [15:0] disp_buf;

  int n_total = 0;
  int n_bad   = 0;

  int cyc = 0;
  int c_evt = 0, c_valid = 0, c_err = 0, c_chg = 0, c_clr = 0;
  int b_evt, b_valid, b_err, b_chg, b_clr;
  int evt_cyc = -1;

  key_entry_ctrl #(
    .DB_CYCLES   (4),
    .CODE_DIGITS (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .key_in     (key_in),
    .sw         (sw),
    .key_evt    (key_evt),
    .code       (code),
    .code_valid (code_valid),
    .cmd_change (cmd_change),
    .cmd_clear  (cmd_clear),
    .entry_err  (entry_err),
    .digit_cnt  (digit_cnt),
    .disp_buf   (disp_buf)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Count high cycles of each pulse output, sampled mid-cycle.
  always @(negedge clk) begin
    if (key_evt) begin
      c_evt   <= c_evt + 1;
      evt_cyc <= cyc;
    end
    if (code_valid) c_valid <= c_valid + 1;
    if (entry_err)  c_err   <= c_err + 1;
    if (cmd_change) c_chg   <= c_chg + 1;
    if (cmd_clear)  c_clr   <= c_clr + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] act,
                          input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic snap();
    b_evt = c_evt; b_valid = c_valid; b_err = c_err;
    b_chg = c_chg; b_clr = c_clr;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press_key(input logic [3:0] v);
    sw = v;
    cycles(3);
    key_in = 1'b0;
    cycles(10);
    key_in = 1'b1;
    cycles(10);
  endtask

  task automatic check_deltas(input string tag, input int evt, input int vld,
                              input int err, input int chg, input int clr);
    check_eq({tag, ".evt"},   c_evt - b_evt,     evt);
    check_eq({tag, ".valid"}, c_valid - b_valid, vld);
    check_eq({tag, ".err"},   c_err - b_err,     err);
    check_eq({tag, ".chg"},   c_chg - b_chg,     chg);
    check_eq({tag, ".clr"},   c_clr - b_clr,     clr);
  endtask

  logic [3:0]  digits4 [4] = '{4'h1, 4'h2, 4'h3, 4'h4};
  logic [15:0] disp_exp [4] = '{16'h0001, 16'h0012, 16'h0123, 16'h1234};
  int t0;

  initial begin
    rst = 1'b1;
    key_in = 1'b1;
    sw = 4'h0;
    cycles(3);
    check_eq("rst.code", code, 16'h0);
    check_eq("rst.disp", disp_buf, 16'h0);
    check_eq("rst.cnt", digit_cnt, 4'd0);
    check_eq("rst.pulses",
             {key_evt, code_valid, cmd_change, cmd_clear, entry_err}, 5'b0);
    rst = 1'b0;
    cycles(6);

    // 1,2,3,4 then enter
    snap();
    for (int i = 0; i < 4; i++) begin
      press_key(digits4[i]);
      check_eq($sformatf("entry.disp%0d", i), disp_buf, disp_exp[i]);
      check_eq($sformatf("entry.cnt%0d", i), digit_cnt, i + 1);
    end
    press_key(4'hD);
    check_deltas("enter", 5, 1, 0, 0, 0);
    check_eq("enter.code", code, 16'h1234);
    check_eq("enter.cnt", digit_cnt, 4'd0);
    check_eq("enter.disp", disp_buf, 16'h0);

    // glitches then a real hold of key E: latency and single event
    snap();
    sw = 4'hE;
    cycles(3);
    key_in = 1'b0; cycles(2);
    key_in = 1'b1; cycles(3);
    key_in = 1'b0; cycles(3);
    key_in = 1'b1; cycles(6);
    check_eq("glitch.evt", c_evt - b_evt, 0);
    t0 = cyc;
    key_in = 1'b0;
    cycles(10);
    key_in = 1'b1;
    cycles(10);
    check_eq("hold.evt", c_evt - b_evt, 1);
    check_eq("hold.latency", evt_cyc - (t0 + 1), 6);
    check_deltas("change", 1, 0, 0, 1, 0);

    // short entry 5,2 then enter
    snap();
    press_key(4'h5);
    press_key(4'h2);
    press_key(4'hD);
    check_deltas("short", 3, 0, 1, 0, 0);
    check_eq("short.code", code, 16'h1234);
    check_eq("short.cnt", digit_cnt, 4'd0);

    // overflow on a fifth digit, then enter
    snap();
    press_key(4'h1);
    press_key(4'h2);
    press_key(4'h3);
    press_key(4'h4);
    press_key(4'h5);
    check_deltas("ovf", 5, 0, 1, 0, 0);
    check_eq("ovf.disp", disp_buf, 16'h1234);
    check_eq("ovf.cnt", digit_cnt, 4'd4);
    snap();
    press_key(4'hD);
    check_deltas("ovf_enter", 1, 1, 0, 0, 0);
    check_eq("ovf_enter.code", code, 16'h1234);

    // clear after two digits, then an invalid key with one digit buffered
    snap();
    press_key(4'h8);
    press_key(4'h9);
    check_eq("clr.pre_disp", disp_buf, 16'h0089);
    press_key(4'hF);
    check_deltas("clr", 3, 0, 0, 0, 1);
    check_eq("clr.cnt", digit_cnt, 4'd0);
    check_eq("clr.disp", disp_buf, 16'h0);
    press_key(4'h6);
    snap();
    press_key(4'hB);
    check_deltas("bad", 1, 0, 1, 0, 0);
    check_eq("bad.cnt", digit_cnt, 4'd1);
    check_eq("bad.disp", disp_buf, 16'h0006);
    press_key(4'hF);

    // reset while the key is held mid-debounce after two digits
    press_key(4'h1);
    press_key(4'h2);
    sw = 4'h3;
    cycles(3);
    key_in = 1'b0;
    cycles(3);
    #4 rst = 1'b1;
    @(negedge clk);
    check_eq("midrst.outs",
             {key_evt, code_valid, cmd_change, cmd_clear, entry_err}, 5'b0);
    check_eq("midrst.cnt", digit_cnt, 4'd0);
    check_eq("midrst.disp", disp_buf, 16'h0);
    check_eq("midrst.code", code, 16'h0);
    cycles(2);
    rst = 1'b0;
    snap();
    cycles(15);
    check_eq("midrst.held_evt", c_evt - b_evt, 0);
    key_in = 1'b1;
    cycles(10);
    check_eq("midrst.rel_evt", c_evt - b_evt, 0);
    press_key(4'h7);
    check_eq("postrst.evt", c_evt - b_evt, 1);
    check_eq("postrst.cnt", digit_cnt, 4'd1);
    check_eq("postrst.disp", disp_buf, 16'h0007);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
